// File: rtl/noc_input_requester_if.sv
// ============================================================================
// Module : noc_input_requester_if
// Brief  : Handshake bundle between an upstream flit source / output arbiters
//          and one router input port requester.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface noc_input_requester_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] in_flit;
  logic              in_ready;
  logic [2:0]        req;
  logic [2:0]        arb_win;
  logic [DATA_W-1:0] out_flit;
  logic              out_valid;
  logic              err_drop;

  // Upstream source, arbiters and crossbar side
  modport master (
    output in_valid, in_flit, arb_win,
    input  in_ready, req, out_flit, out_valid, err_drop
  );

  // Input port requester side
  modport slave (
    input  in_valid, in_flit, arb_win,
    output in_ready, req, out_flit, out_valid, err_drop
  );
endinterface

`default_nettype wire

// File: rtl/noc_input_requester.sv
// ============================================================================
// Module : noc_input_requester
// Brief  : NoC router input port. Buffers flits in a circular FIFO, decodes
//          the head flit destination, drives a one-hot request to the three
//          output arbiters and holds the route from head to tail (wormhole).
//          Optional macro NOC_BAD_DEST_DROP_EN: packets addressed to dest 3
//          are discarded with an err_drop pulse per flit instead of being
//          routed to output 0.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module noc_input_requester #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  noc_input_requester_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOCK = 2'd1;
`ifdef NOC_BAD_DEST_DROP_EN
  localparam logic [1:0] DROP = 2'd2;
`endif

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_TAIL   = 2'b01;
  localparam logic [1:0] T_SINGLE = 2'b11;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [1:0]        sel;
  logic [1:0]        sel_nxt;

  logic              empty;
  logic              push;
  logic              pop;
  logic              pop_drop;
  logic              err;
  logic              bad_dest;
  logic [2:0]        req_c;
  logic [DATA_W-1:0] head;
  logic [1:0]        ftype;
  logic [1:0]        dest;
  logic [1:0]        route;

  // Map a 2-bit output index (0..2) to a one-hot request
  function automatic logic [2:0] onehot(input logic [1:0] d);
    logic [2:0] r;
    r = 3'b000;
    case (d)
      2'd0:    r = 3'b001;
      2'd1:    r = 3'b010;
      2'd2:    r = 3'b100;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
  assign ftype = head[DATA_W-1:DATA_W-2];
  assign dest  = head[1:0];
  // Dest 3 falls back to output 0 whenever it is not being dropped
  assign route = (dest == 2'd3) ? 2'd0 : dest;

`ifdef NOC_BAD_DEST_DROP_EN
  assign bad_dest = (dest == 2'd3);
`else
  assign bad_dest = 1'b0;
`endif

  assign bus.in_ready  = (count != CW'(DEPTH));
  assign bus.req       = req_c;
  assign bus.out_valid = |(req_c & bus.arb_win);
  assign bus.out_flit  = head;
  assign bus.err_drop  = err;

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid | pop_drop;

  // Request, discard and next-state decode from the FIFO head and route state
  always_comb begin
    req_c     = 3'b000;
    pop_drop  = 1'b0;
    err       = 1'b0;
    state_nxt = state;
    sel_nxt   = sel;
    case (state)
      IDLE: begin
        if (!empty) begin
          if (ftype[1]) begin
            if (bad_dest) begin
              pop_drop = 1'b1;
              err      = 1'b1;
`ifdef NOC_BAD_DEST_DROP_EN
              if (ftype != T_SINGLE) state_nxt = DROP;
`endif
            end else begin
              req_c = onehot(route);
              if (bus.out_valid && ftype != T_SINGLE) begin
                state_nxt = LOCK;
                sel_nxt   = route;
              end
            end
          end else begin
            // Stray body/tail outside a packet: discard silently
            pop_drop = 1'b1;
          end
        end
      end
      LOCK: begin
        if (!empty) begin
          req_c = onehot(sel);
          if (bus.out_valid && ftype == T_TAIL) state_nxt = IDLE;
        end
      end
`ifdef NOC_BAD_DEST_DROP_EN
      DROP: begin
        if (!empty) begin
          pop_drop = 1'b1;
          err      = 1'b1;
          if (ftype == T_TAIL) state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_flit;
  end

  // FIFO pointers/occupancy and route state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= IDLE;
      sel    <= 2'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      state <= state_nxt;
      sel   <= sel_nxt;
    end
  end

  // Body flit type constant kept for readability of the decode above
  logic unused_body;
  assign unused_body = ^T_BODY;

endmodule

`default_nettype wire

// File: tb/tb_noc_input_requester.sv
// ============================================================================
// Module : tb_noc_input_requester
// Brief  : Self-checking bench for noc_input_requester: vector table, hand
//          sequences for reset and bad-destination handling, and a random
//          phase compared against a queue-based packet model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_noc_input_requester;

  localparam int DW = 32;
  localparam int DP = 4;
`ifdef NOC_BAD_DEST_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  noc_input_requester_if #(.DATA_W(DW)) bus ();

  noc_input_requester #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic          v;
    logic [31:0]   f;
    logic [2:0]    w;
    logic [2:0]    req;
    logic          ov;
    logic          cf;
    logic [31:0]   of;
    logic          rdy;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] f, input logic [2:0] w);
    bus.in_valid = v;
    bus.in_flit  = f;
    bus.arb_win  = w;
  endtask

  // Packet-level reference state
  logic [31:0] mq[$];
  bit          locked;
  bit          dropping;
  int          route;

  initial begin
    logic [31:0] f;
    logic [1:0]  t;
    int          d;
    logic [2:0]  ereq;
    logic        eov, epop, eerr, erdy, v;
    logic [2:0]  w;
    logic [31:0] nf;
    int          nerr;
    bit          req_seen;

    // Single dest 2, then a streamed packet to dest 1, then stall/full test
    tbl[0]  = '{1'b1, 32'hC000_0002, 3'b100, 3'b000, 1'b0, 1'b0, 32'h0,        1'b1};
    tbl[1]  = '{1'b0, 32'h0,         3'b100, 3'b100, 1'b1, 1'b1, 32'hC000_0002, 1'b1};
    tbl[2]  = '{1'b0, 32'h0,         3'b100, 3'b000, 1'b0, 1'b0, 32'h0,        1'b1};
    tbl[3]  = '{1'b1, 32'h8000_0001, 3'b010, 3'b000, 1'b0, 1'b0, 32'h0,        1'b1};
    tbl[4]  = '{1'b1, 32'h0000_0011, 3'b010, 3'b010, 1'b1, 1'b1, 32'h8000_0001, 1'b1};
    tbl[5]  = '{1'b1, 32'h0000_0021, 3'b010, 3'b010, 1'b1, 1'b1, 32'h0000_0011, 1'b1};
    tbl[6]  = '{1'b1, 32'h4000_0031, 3'b010, 3'b010, 1'b1, 1'b1, 32'h0000_0021, 1'b1};
    tbl[7]  = '{1'b0, 32'h0,         3'b010, 3'b010, 1'b1, 1'b1, 32'h4000_0031, 1'b1};
    tbl[8]  = '{1'b0, 32'h0,         3'b010, 3'b000, 1'b0, 1'b0, 32'h0,        1'b1};
    tbl[9]  = '{1'b1, 32'h8000_0001, 3'b000, 3'b000, 1'b0, 1'b0, 32'h0,        1'b1};
    tbl[10] = '{1'b1, 32'h0000_0011, 3'b000, 3'b010, 1'b0, 1'b1, 32'h8000_0001, 1'b1};
    tbl[11] = '{1'b1, 32'h0000_0021, 3'b101, 3'b010, 1'b0, 1'b1, 32'h8000_0001, 1'b1};
    tbl[12] = '{1'b1, 32'h4000_0031, 3'b000, 3'b010, 1'b0, 1'b1, 32'h8000_0001, 1'b1};
    tbl[13] = '{1'b1, 32'h0000_0099, 3'b000, 3'b010, 1'b0, 1'b1, 32'h8000_0001, 1'b0};
    tbl[14] = '{1'b0, 32'h0,         3'b010, 3'b010, 1'b1, 1'b1, 32'h8000_0001, 1'b0};
    tbl[15] = '{1'b0, 32'h0,         3'b010, 3'b010, 1'b1, 1'b1, 32'h0000_0011, 1'b1};
    tbl[16] = '{1'b0, 32'h0,         3'b010, 3'b010, 1'b1, 1'b1, 32'h0000_0021, 1'b1};
    tbl[17] = '{1'b0, 32'h0,         3'b010, 3'b010, 1'b1, 1'b1, 32'h4000_0031, 1'b1};
    tbl[18] = '{1'b0, 32'h0,         3'b010, 3'b000, 1'b0, 1'b0, 32'h0,        1'b1};

    drive(1'b0, 32'h0, 3'b000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_req", {29'd0, bus.req}, 32'd0);
    chk("reset_ov", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_rdy", {31'd0, bus.in_ready}, 32'd1);
    chk("reset_err", {31'd0, bus.err_drop}, 32'd0);

    // ---------------- table ----------------
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].f, tbl[i].w);
      #1;
      chk($sformatf("tbl%0d_req", i), {29'd0, bus.req}, {29'd0, tbl[i].req});
      chk($sformatf("tbl%0d_ov", i), {31'd0, bus.out_valid}, {31'd0, tbl[i].ov});
      chk($sformatf("tbl%0d_rdy", i), {31'd0, bus.in_ready}, {31'd0, tbl[i].rdy});
      if (tbl[i].cf) chk($sformatf("tbl%0d_flit", i), bus.out_flit, tbl[i].of);
    end

    // ---------------- reset mid-packet ----------------
    @(negedge clk); drive(1'b1, 32'h8000_0001, 3'b000);
    @(negedge clk); drive(1'b1, 32'h0000_0011, 3'b000);
    @(negedge clk); drive(1'b1, 32'h0000_0021, 3'b000);
    @(negedge clk); drive(1'b0, 32'h0, 3'b010);
    #1; chk("mr_head_ov", {31'd0, bus.out_valid}, 32'd1);
    @(negedge clk); drive(1'b0, 32'h0, 3'b000);
    #1; chk("mr_lock_req", {29'd0, bus.req}, 32'b010);
    bus.arb_win = 3'b010;
    rst_n = 1'b0;
    #1;
    chk("mr_rst_req", {29'd0, bus.req}, 32'd0);
    chk("mr_rst_rdy", {31'd0, bus.in_ready}, 32'd1);
    chk("mr_rst_ov", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk); rst_n = 1'b1; drive(1'b1, 32'h8000_0000, 3'b000);
    #1; chk("mr_empty_req", {29'd0, bus.req}, 32'd0);
    @(negedge clk); drive(1'b1, 32'h4000_0000, 3'b001);
    #1; chk("mr_new_req", {29'd0, bus.req}, 32'b001);
    chk("mr_new_flit", bus.out_flit, 32'h8000_0000);
    @(negedge clk); drive(1'b0, 32'h0, 3'b001);
    #1; chk("mr_tail_flit", bus.out_flit, 32'h4000_0000);
    @(negedge clk); drive(1'b0, 32'h0, 3'b000);
    #1; chk("mr_idle_req", {29'd0, bus.req}, 32'd0);

    // ---------------- head to dest 3 + tail ----------------
    nerr = 0;
    req_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0)      drive(1'b1, 32'h8000_0003, 3'b001);
      else if (c == 1) drive(1'b1, 32'h4000_0000, 3'b001);
      else             drive(1'b0, 32'h0, 3'b001);
      #1;
      if (bus.err_drop) nerr++;
      if (bus.req != 3'b000) req_seen = 1'b1;
    end
    chk("bad_err_cnt", nerr, DROP_EN ? 32'd2 : 32'd0);
    chk("bad_req_seen", {31'd0, req_seen}, DROP_EN ? 32'd0 : 32'd1);

    // ---------------- random vs packet model ----------------
    @(negedge clk); rst_n = 1'b0; drive(1'b0, 32'h0, 3'b000);
    @(negedge clk); rst_n = 1'b1;
    mq.delete();
    locked = 1'b0; dropping = 1'b0; route = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      v  = ($urandom_range(0, 3) != 0);
      nf = {2'($urandom_range(0, 3)), 28'($urandom), 2'($urandom_range(0, 3))};
      w  = 3'($urandom_range(0, 7));
      drive(v, nf, w);

      ereq = 3'b000; epop = 1'b0; eerr = 1'b0;
      if (mq.size() != 0) begin
        f = mq[0]; t = f[31:30]; d = int'(f[1:0]);
        if (dropping) begin
          epop = 1'b1; eerr = 1'b1;
        end else if (locked) begin
          ereq = 3'(1 << route);
        end else if (t[1]) begin
          if (d == 3 && DROP_EN) begin epop = 1'b1; eerr = 1'b1; end
          else ereq = 3'(1 << ((d == 3) ? 0 : d));
        end else begin
          epop = 1'b1;
        end
      end
      eov = |(ereq & w);
      if (eov) epop = 1'b1;
      erdy = (mq.size() < DP);

      #1;
      chk("rnd_req", {29'd0, bus.req}, {29'd0, ereq});
      chk("rnd_ov", {31'd0, bus.out_valid}, {31'd0, eov});
      chk("rnd_rdy", {31'd0, bus.in_ready}, {31'd0, erdy});
      chk("rnd_err", {31'd0, bus.err_drop}, {31'd0, eerr});
      if (mq.size() != 0) chk("rnd_flit", bus.out_flit, mq[0]);

      if (epop) begin
        f = mq.pop_front(); t = f[31:30]; d = int'(f[1:0]);
        if (dropping) begin
          if (t == 2'b01) dropping = 1'b0;
        end else if (locked) begin
          if (t == 2'b01) locked = 1'b0;
        end else if (t[1]) begin
          if (eerr) begin
            if (t == 2'b10) dropping = 1'b1;
          end else if (t == 2'b10) begin
            locked = 1'b1;
            route  = (d == 3) ? 0 : d;
          end
        end
      end
      if (v && erdy) mq.push_back(nf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

`default_nettype wire
